gaussian_filter_accel_mac_pipe: RTL and testbench
=================================================

// Module: gaussian_filter_accel_mac_pipe
// PURPOSE
//   Parametrised successor to the fixed 16x16 four-stage multiplier used by the Gaussian
//   filter datapath. It is a LANES-wide pipelined multiply-accumulate with valid/ready
//   backpressure, per-operand signedness and framed accumulation (first/last).
//   It sits between the line-buffer window tap and the normalisation/pack stage, so one
//   instance computes LANES kernel dot-products in parallel.
// PARAMETERS
//   LANES     3   independent MAC lanes (>=1)
//   A_W       16  pixel operand width per lane
//   B_W       16  coefficient operand width per lane
//   ACC_W     40  accumulator width; must be >= A_W+B_W (elaboration $error otherwise)
//   OUT_W     16  output width per lane
//   NUM_STAGE 4   multiply latency in cycles (>=2: input reg, product reg, NUM_STAGE-2 retime regs)
//   SIGNED_A  0   1: in_a lanes are two's complement; 0: zero-extended
//   SIGNED_B  0   1: in_b lanes are two's complement; 0: zero-extended
//   SHIFT     8   right shift applied to the accumulator at output (normalisation, < ACC_W)
// PORTS
//   clk        in   1            rising-edge clock
//   reset_n    in   1            asynchronous, active-low reset
//   in_valid   in   1            input beat valid
//   in_ready   out  1            input beat accepted when in_valid & in_ready
//   in_a       in   LANES*A_W    lane i = [i*A_W +: A_W]
//   in_b       in   LANES*B_W    lane i = [i*B_W +: B_W]
//   in_first   in   1            beat starts a new sum (acc := product)
//   in_last    in   1            beat ends the sum; produces one output beat
//   out_valid  out  1            result valid; held until out_ready
//   out_ready  in   1            downstream accepts the result
//   out_data   out  LANES*OUT_W  lane i = [i*OUT_W +: OUT_W]
//   out_ovf    out  LANES        per-lane saturation flag (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async assert, sync release): every pipe valid bit, every accumulator, out_valid,
//     out_data and out_ovf go to 0; in_ready is 0 while reset_n is low. A reset asserted mid-frame
//     discards the partial sums and all in-flight beats.
//   - Global stall: adv = ~out_valid | out_ready, and in_ready = adv. All pipe registers, including
//     the accumulator, update only when adv=1. A bubble (in_valid=0) advances as valid=0.
//   - Product: sign- or zero-extend each operand per SIGNED_*, form an (A_W+B_W)-bit product,
//     then extend it to ACC_W.
//   - Accumulate stage (after NUM_STAGE): for a valid beat, acc := first ? p : acc+p, with wrap
//     modulo 2^ACC_W. first and last travel down the pipe alongside the data.
//   - Output: a valid beat with last=1 loads out_data and sets out_valid. A beat with first=1 and
//     last=1 is a single-term sum. Non-last beats never raise out_valid.
//   - A beat with last=1 and no preceding first continues from the current acc (0 after reset).
//   - Latency: accepted last beat -> out_valid is NUM_STAGE+1 cycles with no stall.
//     Throughput is 1 beat/cycle while out_ready=1.
//   - out_valid=1 & out_ready=0: the whole pipe freezes, so out_data and out_valid stay stable.
//   - Simultaneous out_ready and a new result in the same cycle: the old result is consumed and
//     the new one is loaded, so out_valid stays 1.
// CONFIGURATION
//   Macro GAUSSIAN_FILTER_ACCEL_MAC_SAT_EN:
//   - defined: out = (acc + 2^(SHIFT-1)) >>> SHIFT, which rounds half up (no rounding add when
//     SHIFT=0). The result is then saturated to the OUT_W range, signed if SIGNED_A|SIGNED_B,
//     else unsigned. out_ovf[i]=1 when lane i clipped; it is registered with out_data.
//   - undefined: out = (acc >>> SHIFT)[OUT_W-1:0], which truncates and wraps. out_ovf is tied 0.
//   - A negative sum in unsigned mode is impossible, so no clamp is needed there.
// STRUCTURE
//   Package gaussian_filter_accel_pkg holds:
//   - the ACC_W/SHIFT defaults
//   - the function sat_round(acc, shift, out_w, is_signed)
//   - the typedef mac_ctl_t {valid, first, last} that travels down the pipe
//   Sub-module gaussian_filter_accel_mac_lane is one lane: extend, multiply, retime, accumulate,
//   round. It is generated LANES times. The top owns the mac_ctl_t shift register, adv,
//   in_ready and out_valid.
// TESTING
//   1 LANES=3, 3-beat frame, a={10,20,30}, b={1,2,1}, out_ready=1 ->
//     one out_valid, 5 cycles after the last beat.
//   2 Single beat first=last=1, a=255, b=256, SHIFT=8 ->
//     out=255, out_ovf=0; back-to-back single beats give 1 result/cycle.
//   3 Hold out_ready=0 for 6 cycles while a frame is in flight ->
//     in_ready=0, out_data stable, no beat lost or duplicated after release.
//   4 SAT_EN, unsigned, a=b=0xFFFF over 4 beats, SHIFT=8, OUT_W=16 ->
//     out=0xFFFF, out_ovf=1. Without the macro -> out=(4*0xFFFE0001>>8)&0xFFFF.
//   5 SIGNED_A=1, a=-3 (0xFFFD), b=5, single beat, SHIFT=0 -> out=0xFFF1 (-15).
//   6 Drop reset_n mid-frame after 2 beats, release, then send a new 1-beat frame a=7, b=1 ->
//     no stale output appears, out=7 (SHIFT=0).

Source files
------------

// File: rtl/gaussian_filter_accel_pkg.sv
// Shared types, defaults and the output rounding/saturation helper for the
// Gaussian filter MAC pipe.
package gaussian_filter_accel_pkg;

    localparam int ACC_W_DEF = 40;
    localparam int SHIFT_DEF = 8;
    // Working width of sat_round; accumulators are extended to this width first.
    localparam int SR_W      = 64;

    // Per-beat control that travels down the pipe beside the data.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } mac_ctl_t;

    // Round half up, shift right, then clip to the out_w range.
    // acc must already be sign/zero-extended to SR_W. Returns {ovf, value}.
    function automatic logic [SR_W:0] sat_round(input logic [SR_W-1:0] acc,
                                                input int              shift,
                                                input int              out_w,
                                                input bit              is_signed);
        logic [SR_W-1:0] sum;
        logic [SR_W-1:0] sh;
        logic [SR_W-1:0] hi;
        logic [SR_W-1:0] lo;
        logic            ovf;
        ovf = 1'b0;
        sum = acc;
        if (shift > 0)
            sum = acc + (SR_W'(1) << (shift - 1));
        if (is_signed) begin
            sh = SR_W'($signed(sum) >>> shift);
            hi = (SR_W'(1) << (out_w - 1)) - SR_W'(1);
            lo = ~hi;
            if ($signed(sh) > $signed(hi)) begin
                sh  = hi;
                ovf = 1'b1;
            end else if ($signed(sh) < $signed(lo)) begin
                sh  = lo;
                ovf = 1'b1;
            end
        end else begin
            sh = sum >> shift;
            hi = (SR_W'(1) << out_w) - SR_W'(1);
            if (sh > hi) begin
                sh  = hi;
                ovf = 1'b1;
            end
        end
        return {ovf, sh};
    endfunction

endpackage

// File: rtl/gaussian_filter_accel_mac_lane.sv
// One MAC lane: operand extend, multiply, retime, accumulate, round/pack.
// Macro GAUSSIAN_FILTER_ACCEL_MAC_SAT_EN selects rounding + saturation at the
// output; otherwise the shifted accumulator is truncated and out_ovf is 0.
module gaussian_filter_accel_mac_lane
    import gaussian_filter_accel_pkg::*;
#(
    parameter int A_W       = 16,
    parameter int B_W       = 16,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int OUT_W     = 16,
    parameter int NUM_STAGE = 4,
    parameter bit SIGNED_A  = 1'b0,
    parameter bit SIGNED_B  = 1'b0,
    parameter int SHIFT     = SHIFT_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             adv,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  mac_ctl_t         acc_ctl,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int P_W       = A_W + B_W;
    localparam bit IS_SIGNED = SIGNED_A | SIGNED_B;

    logic [A_W-1:0]   a_q;
    logic [B_W-1:0]   b_q;
    logic [P_W-1:0]   a_x;
    logic [P_W-1:0]   b_x;
    logic [P_W-1:0]   p_q [2:NUM_STAGE];
    logic [ACC_W-1:0] acc_p;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_nxt;
    logic [SR_W-1:0]  acc_x;
    logic [SR_W:0]    res;
    logic [OUT_W-1:0] res_data;
    logic             res_ovf;
    logic             unused_res_hi;

    // Operand and product extension; a P_W-bit product is exact for any signedness mix.
    always_comb begin
        a_x   = SIGNED_A  ? P_W'($signed(a_q)) : P_W'(a_q);
        b_x   = SIGNED_B  ? P_W'($signed(b_q)) : P_W'(b_q);
        acc_p = IS_SIGNED ? ACC_W'($signed(p_q[NUM_STAGE])) : ACC_W'(p_q[NUM_STAGE]);
    end

    // Input register and product register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q    <= '0;
            b_q    <= '0;
            p_q[2] <= '0;
        end else if (adv) begin
            a_q    <= a;
            b_q    <= b;
            p_q[2] <= a_x * b_x;
        end
    end

    // Retime registers so the multiplier can be balanced across NUM_STAGE-2 extra cycles.
    for (genvar s = 3; s <= NUM_STAGE; s++) begin : g_retime
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                p_q[s] <= '0;
            else if (adv)
                p_q[s] <= p_q[s-1];
        end
    end

    // The output is formed from the next accumulator value so it lands with the acc update.
    always_comb begin
        acc_nxt = acc_ctl.first ? acc_p : acc_q + acc_p;
        acc_x   = IS_SIGNED ? SR_W'($signed(acc_nxt)) : SR_W'(acc_nxt);
`ifdef GAUSSIAN_FILTER_ACCEL_MAC_SAT_EN
        res     = sat_round(acc_x, SHIFT, OUT_W, IS_SIGNED);
`else
        res     = {1'b0, SR_W'($signed(acc_x) >>> SHIFT)};
`endif
        res_data = res[OUT_W-1:0];
        res_ovf  = res[SR_W];
    end

    assign unused_res_hi = ^res[SR_W-1:OUT_W];

    // Accumulator and registered output; both hold while the pipe is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (adv && acc_ctl.valid) begin
            acc_q <= acc_nxt;
            if (acc_ctl.last) begin
                out_data <= res_data;
                out_ovf  <= res_ovf;
            end
        end
    end

endmodule

// File: rtl/gaussian_filter_accel_mac_pipe.sv
// LANES-wide pipelined multiply-accumulate with framed sums and a global
// valid/ready stall. Optional rounding/saturation: GAUSSIAN_FILTER_ACCEL_MAC_SAT_EN.
module gaussian_filter_accel_mac_pipe
    import gaussian_filter_accel_pkg::*;
#(
    parameter int LANES     = 3,
    parameter int A_W       = 16,
    parameter int B_W       = 16,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int OUT_W     = 16,
    parameter int NUM_STAGE = 4,
    parameter bit SIGNED_A  = 1'b0,
    parameter bit SIGNED_B  = 1'b0,
    parameter int SHIFT     = SHIFT_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*A_W-1:0]   in_a,
    input  logic [LANES*B_W-1:0]   in_b,
    input  logic                   in_first,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       out_ovf
);

    if (LANES < 1) begin : g_bad_lanes
        $error("LANES must be >= 1");
    end
    if (ACC_W < A_W + B_W) begin : g_bad_acc_w
        $error("ACC_W must be >= A_W+B_W");
    end
    if (ACC_W >= SR_W) begin : g_bad_acc_max
        $error("ACC_W must be below the rounding helper width");
    end
    if (NUM_STAGE < 2) begin : g_bad_stage
        $error("NUM_STAGE must be >= 2");
    end
    if (SHIFT >= ACC_W) begin : g_bad_shift
        $error("SHIFT must be < ACC_W");
    end

    logic     adv;
    mac_ctl_t ctl_in;
    mac_ctl_t ctl_pipe [1:NUM_STAGE];

    // One stall for the whole pipe: advance unless a held result is waiting.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & reset_n;
    assign ctl_in   = '{valid: in_valid, first: in_first, last: in_last};

    // Control shift register; bubbles travel as valid=0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 1; s <= NUM_STAGE; s++)
                ctl_pipe[s] <= '0;
        end else if (adv) begin
            ctl_pipe[1] <= ctl_in;
            for (int s = 2; s <= NUM_STAGE; s++)
                ctl_pipe[s] <= ctl_pipe[s-1];
        end
    end

    // A last beat loads a result; an accepted old result with no new one clears valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            out_valid <= 1'b0;
        else if (adv)
            out_valid <= ctl_pipe[NUM_STAGE].valid & ctl_pipe[NUM_STAGE].last;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gaussian_filter_accel_mac_lane #(
            .A_W       (A_W),
            .B_W       (B_W),
            .ACC_W     (ACC_W),
            .OUT_W     (OUT_W),
            .NUM_STAGE (NUM_STAGE),
            .SIGNED_A  (SIGNED_A),
            .SIGNED_B  (SIGNED_B),
            .SHIFT     (SHIFT)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .adv      (adv),
            .a        (in_a[i*A_W +: A_W]),
            .b        (in_b[i*B_W +: B_W]),
            .acc_ctl  (ctl_pipe[NUM_STAGE]),
            .out_data (out_data[i*OUT_W +: OUT_W]),
            .out_ovf  (out_ovf[i])
        );
    end

endmodule

// File: tb/tb_gaussian_filter_accel_mac_pipe.sv
// Directed bench for gaussian_filter_accel_mac_pipe. Two instances share the
// stimulus: dut (defaults, unsigned, SHIFT=8) and dut_s (SIGNED_A=1, SHIFT=0).
// Expected values follow GAUSSIAN_FILTER_ACCEL_MAC_SAT_EN when it is defined.
module tb_gaussian_filter_accel_mac_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_first, in_last, out_ready;
    logic [47:0] in_a, in_b;
    logic        in_ready, out_valid;
    logic [47:0] out_data;
    logic [2:0]  out_ovf;
    logic        in_ready_s, out_valid_s;
    logic [47:0] out_data_s;
    logic [2:0]  out_ovf_s;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [47:0] q_d  [$];
    logic [2:0]  q_o  [$];
    int          q_t  [$];
    logic [47:0] qs_d [$];
    logic [2:0]  qs_o [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gaussian_filter_accel_mac_pipe dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    gaussian_filter_accel_mac_pipe #(.SIGNED_A(1'b1), .SHIFT(0)) dut_s (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_ovf(out_ovf_s)
    );

    // Record every output handshake, mid-cycle.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            q_d.push_back(out_data);
            q_o.push_back(out_ovf);
            q_t.push_back(cyc);
        end
        if (reset_n && out_valid_s && out_ready) begin
            qs_d.push_back(out_data_s);
            qs_o.push_back(out_ovf_s);
        end
    end

    function automatic logic [47:0] pk(input logic [15:0] x0, x1, x2);
        return {x2, x1, x0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pop one result from either instance's queue and compare data and overflow.
    task automatic chk_pop(input string tag, input bit sgn, input logic [47:0] d, input logic [2:0] o);
        logic [47:0] gd;
        logic [2:0]  go;
        if ((sgn ? qs_d.size() : q_d.size()) == 0) begin
            chk({tag, "_missing"}, 0, 1);
        end else begin
            if (sgn) begin
                gd = qs_d.pop_front();
                go = qs_o.pop_front();
            end else begin
                gd = q_d.pop_front();
                go = q_o.pop_front();
                void'(q_t.pop_front());
            end
            chk({tag, "_data"}, 64'(gd), 64'(d));
            chk({tag, "_ovf"}, 64'(go), 64'(o));
        end
    endtask

    task automatic flush();
        q_d.delete(); q_o.delete(); q_t.delete(); qs_d.delete(); qs_o.delete();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic f, input logic l, input logic [47:0] a, input logic [47:0] b);
        bit ok;
        in_valid = 1'b1; in_first = f; in_last = l; in_a = a; in_b = b;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    int n;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_a = '0; in_b = '0; out_ready = 1'b1;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_out_ovf", 64'(out_ovf), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        idle(2);

        // 1: three-beat frame, latency from the cycle the last beat is presented
        flush();
        send(1'b1, 1'b0, pk(10, 2560, 5120),  pk(1, 1, 1));
        send(1'b0, 1'b0, pk(20, 5120, 10240), pk(2, 2, 2));
        chk("t1_no_early_valid", 64'(out_valid), 0);
        in_valid = 1'b1; in_first = 1'b0; in_last = 1'b1;
        in_a = pk(30, 7680, 15360); in_b = pk(1, 1, 1);
        n = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            n++;
        end while (!out_valid && n < 20);
        chk("t1_latency", 64'(n), 5);
        idle(1);
        chk("t1_valid_drop", 64'(out_valid), 0);
        idle(2);
        chk("t1_count", 64'(q_d.size()), 1);
        chk_pop("t1", 1'b0, pk(0, 80, 160), 3'b000);
`ifdef GAUSSIAN_FILTER_ACCEL_MAC_SAT_EN
        chk_pop("t1s", 1'b1, pk(80, 20480, 16'h7FFF), 3'b100);
`else
        chk_pop("t1s", 1'b1, pk(80, 20480, 16'hA000), 3'b000);
`endif

        // 2: single-term sums, back to back
        flush();
        send(1'b1, 1'b1, pk(255, 255, 255),    pk(256, 256, 256));
        send(1'b1, 1'b1, pk(100, 200, 300),    pk(256, 256, 256));
        send(1'b1, 1'b1, pk(1000, 2000, 3000), pk(256, 256, 256));
        send(1'b1, 1'b1, pk(7, 8, 9),          pk(256, 256, 256));
        idle(10);
        chk("t2_count", 64'(q_d.size()), 4);
        if (q_t.size() == 4) begin
            chk("t2_gap1", 64'(q_t[1] - q_t[0]), 1);
            chk("t2_gap3", 64'(q_t[3] - q_t[0]), 3);
        end
        chk_pop("t2a", 1'b0, pk(255, 255, 255), 3'b000);
        chk_pop("t2b", 1'b0, pk(100, 200, 300), 3'b000);
        chk_pop("t2c", 1'b0, pk(1000, 2000, 3000), 3'b000);
        chk_pop("t2d", 1'b0, pk(7, 8, 9), 3'b000);

        // 3: downstream stall with results in flight
        flush();
        out_ready = 1'b0;
        send(1'b1, 1'b1, pk(11, 12, 13), pk(256, 256, 256));
        send(1'b1, 1'b1, pk(21, 22, 23), pk(256, 256, 256));
        send(1'b1, 1'b1, pk(31, 32, 33), pk(256, 256, 256));
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t3_valid", 64'(out_valid), 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t3_in_ready", 64'(in_ready), 0);
            chk("t3_hold_data", 64'(out_data), 64'(pk(11, 12, 13)));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        idle(10);
        chk("t3_count", 64'(q_d.size()), 3);
        chk_pop("t3a", 1'b0, pk(11, 12, 13), 3'b000);
        chk_pop("t3b", 1'b0, pk(21, 22, 23), 3'b000);
        chk_pop("t3c", 1'b0, pk(31, 32, 33), 3'b000);

        // 4: four full-scale unsigned products
        flush();
        send(1'b1, 1'b0, '1, '1);
        send(1'b0, 1'b0, '1, '1);
        send(1'b0, 1'b0, '1, '1);
        send(1'b0, 1'b1, '1, '1);
        idle(8);
`ifdef GAUSSIAN_FILTER_ACCEL_MAC_SAT_EN
        chk_pop("t4", 1'b0, pk(16'hFFFF, 16'hFFFF, 16'hFFFF), 3'b111);
        chk_pop("t4s", 1'b1, pk(16'h8000, 16'h8000, 16'h8000), 3'b111);
`else
        chk_pop("t4", 1'b0, pk(16'hF800, 16'hF800, 16'hF800), 3'b000);
        chk_pop("t4s", 1'b1, pk(16'h0004, 16'h0004, 16'h0004), 3'b000);
`endif

        // 5: negative pixel in signed mode
        flush();
        send(1'b1, 1'b1, pk(16'hFFFD, 16'hFFFD, 16'hFFFD), pk(5, 5, 5));
        idle(8);
        chk_pop("t5s", 1'b1, pk(16'hFFF1, 16'hFFF1, 16'hFFF1), 3'b000);
`ifdef GAUSSIAN_FILTER_ACCEL_MAC_SAT_EN
        chk_pop("t5", 1'b0, pk(16'h0500, 16'h0500, 16'h0500), 3'b000);
`else
        chk_pop("t5", 1'b0, pk(16'h04FF, 16'h04FF, 16'h04FF), 3'b000);
`endif

        // 6: reset mid-frame clears partial sums and in-flight beats
        flush();
        send(1'b1, 1'b0, pk(256, 256, 256), pk(16, 16, 16));
        send(1'b0, 1'b0, pk(256, 256, 256), pk(16, 16, 16));
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_in_ready", 64'(in_ready), 0);
        chk("t6_rst_valid", 64'(out_valid_s), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        idle(1);
        send(1'b0, 1'b1, pk(7, 7, 7), pk(1, 1, 1));
        idle(10);
        chk("t6_count", 64'(qs_d.size()), 1);
        chk_pop("t6s", 1'b1, pk(7, 7, 7), 3'b000);
        chk_pop("t6", 1'b0, pk(0, 0, 0), 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
